// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial LSB-first a - b using one full-subtractor cell
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sd_next;

  // Full-subtractor cell on the current LSBs
  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0
  assign w_sd_next = {w_d, r_sd};
  assign w_last    = (r_cnt == C_LAST);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sd  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_sd  <= w_sd_next[WIDTH-1:1];
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_sd_next;
            r_borrow <= w_br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_SHIFT);
      r_done <= (w_state_next == S_DONE);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : random and directed checks of serial_subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_checks;
  int n_errors;
  bit run_cmp;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since acceptance plus plain arithmetic
  int           k;
  logic [W:0]   pend;
  logic [W-1:0] m_diff;
  logic         m_borrow;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        = 0;
      m_diff   = '0;
      m_borrow = 1'b0;
    end else if (k == 0) begin
      if (start) begin
        k    = 1;
        pend = {1'b0, a} - {1'b0, b};
      end
    end else if (k <= W) begin
      k++;
      if (k == W + 1) {m_borrow, m_diff} = pend;
    end else begin
      k = 0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("busy",   {31'd0, busy},   {31'd0, (k >= 1 && k <= W)});
      chk("done",   {31'd0, done},   {31'd0, (k == W + 1)});
      chk("diff",   {24'd0, diff},   {24'd0, m_diff});
      chk("borrow", {31'd0, borrow}, {31'd0, m_borrow});
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, output int lat);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic op_expect(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [W-1:0] ed, input logic eb);
    int lat;
    run_op(ta, tb_, lat);
    chk({nm, "_diff"},   {24'd0, diff},   {24'd0, ed});
    chk({nm, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    n_checks = 0;
    n_errors = 0;
    run_cmp  = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_diff",   {24'd0, diff},   32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    // Directed values and latency
    run_op(8'd5, 8'd3, lat);
    chk("latency", lat, W + 1);
    chk("d5m3_diff",   {24'd0, diff},   32'h02);
    chk("d5m3_borrow", {31'd0, borrow}, 32'd0);
    op_expect("d3m5",  8'd3,   8'd5,   8'hFE, 1'b1);
    op_expect("d0m1",  8'd0,   8'd1,   8'hFF, 1'b1);
    op_expect("aeqb",  8'h77,  8'h77,  8'h00, 1'b0);
    op_expect("bzero", 8'h9C,  8'h00,  8'h9C, 1'b0);
    op_expect("dFFm1", 8'hFF,  8'h01,  8'hFE, 1'b0);

    // Held-over result across idle
    repeat (3) @(negedge clk);
    chk("hold_diff", {24'd0, diff}, 32'hFE);

    // Asynchronous reset at bit 4
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy},   32'd0);
    chk("arst_done",   {31'd0, done},   32'd0);
    chk("arst_diff",   {24'd0, diff},   32'd0);
    chk("arst_borrow", {31'd0, borrow}, 32'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    op_expect("after_rst", 8'hA5, 8'h3C, 8'h69, 1'b0);

    // Start pulses during SHIFT and DONE are ignored
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1; a = 8'h40; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    chk("ign_diff", {24'd0, diff}, 32'h02);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    op_expect("next_ok", 8'h10, 8'h20, 8'hF0, 1'b1);

    // start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    gap   = 0;
    lat   = 0;
    while (!done && lat < 40) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      lat++;
    end
    a = W'($urandom); b = W'($urandom);
    @(negedge clk);
    while (!done && gap < 40) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      gap++;
    end
    chk("done_spacing", gap + 1, W + 2);
    repeat (60) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // Random traffic, with equal and zero operands mixed in
    for (int i = 0; i < 15000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = '0;
        2:       begin a = '0; b = 8'd1; end
        default: b = W'($urandom);
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
